matrix_bank: RTL
================

# matrix_bank

Parametrised multi-matrix storage: NUM_MAT matrices of ROWS×COLS words, each DATA_W bits, all zeroed on reset. Provides:
- an independent random write port;
- a registered random read port;
- a valid/ready row-major streaming engine that reads out a whole matrix;
- a sequenced per-matrix clear engine.

It is the storage block between the matrix-entry front end and the matrix arithmetic units.

## Interface
Parameters:
- NUM_MAT, 3, number of matrices
- ROWS, 3, rows per matrix
- COLS, 3, columns per matrix
- DATA_W, 8, word width
- Derived widths: MAT_W = max(1, clog2(NUM_MAT)), ROW_W = max(1, clog2(ROWS)), COL_W = max(1, clog2(COLS))

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- wr_en  in  1  random write strobe
- wr_mat / wr_row / wr_col  in  MAT_W / ROW_W / COL_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  random read strobe
- rd_mat / rd_row / rd_col  in  MAT_W / ROW_W / COL_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data holds the result of the previous cycle's rd_en
- str_start  in  1  start streaming matrix str_mat
- str_mat  in  MAT_W  matrix to stream
- str_data  out  DATA_W  stream word
- str_valid  out  1  str_data valid
- str_ready  in  1  consumer accepts str_data
- str_last  out  1  current word is element (ROWS-1, COLS-1)
- clr_start  in  1  start clearing matrix clr_mat
- clr_mat  in  MAT_W  matrix to clear
- busy  out  1  engine state ≠ IDLE
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation
- Reset (reset=0): all words = 0; rd_data = 0; rd_valid = 0; str_data = 0; str_valid = 0; str_last = 0; busy = 0; err = 0; FSM → IDLE. Reset is asynchronous and may abort any stream or clear mid-way; the next cycle after release starts in IDLE.
- Address validity: mat < NUM_MAT, row < ROWS, col < COLS.
  - Invalid write: dropped, err set.
  - Invalid read: returns 0, err set.
  - str_start or clr_start with an out-of-range matrix: ignored, err set.
- err is sticky. err_clr clears it; a new error raised in the same cycle wins (err stays 1).
- Single storage write port. Priority: clear engine > wr_en. An external write issued while the engine is in CLEAR is dropped and sets err. External writes are legal during STREAM.
- FSM states: IDLE, STREAM, CLEAR.
  - IDLE → CLEAR on a valid clr_start. clr_start has priority over a simultaneous str_start; the str_start is ignored silently.
  - IDLE → STREAM on a valid str_start.
  - Starts are ignored while busy (no error).
  - STREAM: the index walks row-major (0,0), (0,1) … (ROWS-1, COLS-1). The index advances only on a handshake (str_valid & str_ready). The handshake on the str_last word → IDLE.
  - CLEAR: one zero written per cycle, row-major, ROWS*COLS cycles, then → IDLE.
- Read-during-write at the same address, on either the random port or the stream fetch: returns old data.
- The random read port operates in every state, including CLEAR.

## Timing
- Random read: rd_en at edge T → rd_data and rd_valid at T+1. rd_valid = 0 in a cycle after no rd_en; rd_data then holds its last value.
- Write: visible to reads issued from the edge after wr_en.
- STREAM:
  - str_start at edge T → str_valid = 1 with element (0,0) from T+1.
  - str_data, str_valid and str_last are registered.
  - They hold stable while str_valid & !str_ready.
  - After a handshake, the next element appears the following cycle. With str_ready held at 1, throughput is 1 word/cycle and ROWS*COLS words take exactly ROWS*COLS cycles.
  - After the final handshake: str_valid = 0 and str_last = 0 next cycle; IDLE.
  - Each word reflects memory content at its own fetch edge; stream words are not a snapshot.
- CLEAR: clr_start at edge T → busy = 1 from T+1. Zero writes occur at edges T+1 … T+ROWS*COLS; busy = 0 from T+ROWS*COLS+1.
- busy = 1 throughout STREAM, from the edge after str_start to the edge after the final handshake.
- Minimum gap between operations: a new start is accepted in the first cycle busy = 0.

## Test plan
- Reset/readback, default params: reset low mid-simulation → every address reads 0 with rd_valid = 1 one cycle after rd_en; err = 0, busy = 0.
- Write/read: write 8'hA5 to (2,1,0) → rd_en at (2,1,0) returns A5 next cycle. Write and read the same address in one cycle → old value, then A5 on the following read.
- Stream with backpressure: fill matrix 1 with values 1..9 and stream it. str_ready pattern 1,0,0,1,1,… → words 1..9 in order, each held while ready = 0, str_last only on 9, busy drops after the 9th handshake.
- Clear with conflict: matrix 0 holds nonzero data; clr_start(0) plus wr_en to (0,0,0) 3 cycles later → all of matrix 0 = 0, err = 1, busy for exactly 9 cycles. Matrix 1 contents unchanged.
- Errors: wr_mat = 3 with NUM_MAT = 3 → write dropped, err = 1. A read at row 3 → 0. err_clr → err = 0.
- Param sweep and mid-op reset: NUM_MAT = 4, ROWS = 2, COLS = 5, DATA_W = 16 → stream of 10 words, str_last on the 10th. Assert reset during word 4 → all outputs 0 immediately and IDLE after release.

Source files
------------

// File: rtl/matrix_bank.sv
// Purpose: NUM_MAT x ROWS x COLS word store with random write/read, row-major stream engine and per-matrix clear engine.
// Latency: random read 1 cycle; stream first word 1 cycle after start; clear takes ROWS*COLS cycles.
// Backpressure: stream words held while str_valid & !str_ready; starts ignored while busy.
module matrix_bank #(
    parameter  int NUM_MAT = 3,
    parameter  int ROWS    = 3,
    parameter  int COLS    = 3,
    parameter  int DATA_W  = 8,
    localparam int MAT_W   = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1,
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [MAT_W-1:0]  wr_mat,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [MAT_W-1:0]  rd_mat,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              str_start,
    input  logic [MAT_W-1:0]  str_mat,
    output logic [DATA_W-1:0] str_data,
    output logic              str_valid,
    input  logic              str_ready,
    output logic              str_last,
    input  logic              clr_start,
    input  logic [MAT_W-1:0]  clr_mat,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, CLEAR = 2'd2} state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [NUM_MAT][ROWS][COLS];
    logic [MAT_W-1:0]  op_mat;
    logic [ROW_W-1:0]  idx_row, nxt_row;
    logic [COL_W-1:0]  idx_col, nxt_col;
    logic              idx_last, nxt_last;
    logic              wr_ok, rd_ok, str_ok, clr_ok;
    logic              go_clr, go_str, str_hs, wr_hit, err_set;

    assign wr_ok  = (32'(wr_mat) < 32'(NUM_MAT)) && (32'(wr_row) < 32'(ROWS)) && (32'(wr_col) < 32'(COLS));
    assign rd_ok  = (32'(rd_mat) < 32'(NUM_MAT)) && (32'(rd_row) < 32'(ROWS)) && (32'(rd_col) < 32'(COLS));
    assign str_ok = 32'(str_mat) < 32'(NUM_MAT);
    assign clr_ok = 32'(clr_mat) < 32'(NUM_MAT);

    // A valid clear wins over a simultaneous stream start; an invalid clear does not block it.
    assign go_clr = (state == IDLE) && clr_start && clr_ok;
    assign go_str = (state == IDLE) && str_start && str_ok && !go_clr;
    assign str_hs = (state == STREAM) && str_valid && str_ready;
    assign wr_hit = wr_en && wr_ok && (state != CLEAR);

    assign err_set = (wr_en && (!wr_ok || (state == CLEAR)))
                   || (rd_en && !rd_ok)
                   || ((state == IDLE) && clr_start && !clr_ok)
                   || ((state == IDLE) && str_start && !str_ok && !go_clr);

    assign busy     = (state != IDLE);
    assign idx_last = (idx_row == LAST_ROW) && (idx_col == LAST_COL);
    assign nxt_last = (nxt_row == LAST_ROW) && (nxt_col == LAST_COL);

    always_comb begin
        nxt_row = idx_row;
        nxt_col = idx_col + 1'b1;
        if (idx_col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = (idx_row == LAST_ROW) ? '0 : idx_row + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_clr) state_nxt = CLEAR;
                     else if (go_str) state_nxt = STREAM;
            STREAM:  if (str_hs && str_last) state_nxt = IDLE;
            CLEAR:   if (idx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Engine index and registered stream outputs; each word is fetched at its own advance edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_mat    <= '0;
            idx_row   <= '0;
            idx_col   <= '0;
            str_data  <= '0;
            str_valid <= 1'b0;
            str_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go_clr) begin
                        op_mat  <= clr_mat;
                        idx_row <= '0;
                        idx_col <= '0;
                    end else if (go_str) begin
                        op_mat    <= str_mat;
                        idx_row   <= '0;
                        idx_col   <= '0;
                        str_data  <= mem[str_mat][0][0];
                        str_valid <= 1'b1;
                        str_last  <= (ROWS * COLS == 1);
                    end
                end
                STREAM: begin
                    if (str_hs) begin
                        if (str_last) begin
                            str_valid <= 1'b0;
                            str_last  <= 1'b0;
                        end else begin
                            idx_row  <= nxt_row;
                            idx_col  <= nxt_col;
                            str_data <= mem[op_mat][nxt_row][nxt_col];
                            str_last <= nxt_last;
                        end
                    end
                end
                CLEAR: begin
                    idx_row <= nxt_row;
                    idx_col <= nxt_col;
                end
                default: ;
            endcase
        end
    end

    // Single write port: clear engine owns it while in CLEAR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < NUM_MAT; m++)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        mem[m][r][c] <= '0;
        end else if (state == CLEAR) begin
            mem[op_mat][idx_row][idx_col] <= '0;
        end else if (wr_hit) begin
            mem[wr_mat][wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_ok ? mem[rd_mat][rd_row][rd_col] : '0;
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end
endmodule
